dm_access_ctrl: RTL and testbench
=================================

// Module: dm_access_ctrl
// PURPOSE
//   Sequences one data-memory access per MEM-stage load/store over a req/ack bus with variable wait states.
//   Stalls the pipeline until the access completes or times out.
//   Checks alignment, generates byte enables and replicates store data for sub-word stores.
//   Sign/zero-extends the selected byte or halfword for sub-word loads (lb/lbu/lh/lhu/lw).
//   Sits between the MEM stage and the data memory; the MEM/WB register consumes its result.
// PARAMETERS
//   MAX_WAIT  15  max BUS cycles without mem_ack before timeout (1..255)
// PORTS
//   clk          in   1   clock; all state changes on rising edge
//   reset        in   1   synchronous, active-high reset
//   op_valid     in   1   MEM-stage load/store present; held stable while stall=1
//   op_store     in   1   1=store, 0=load
//   op_size      in   2   00 word, 01 half, 10 byte, 11 illegal
//   op_unsigned  in   1   loads only: 1=zero-extend, 0=sign-extend
//   addr         in   32  byte address
//   wdata        in   32  store data (low bits used for sub-word)
//   stall        out  1   freeze IF..MEM stages
//   mem_req      out  1   bus request; held until mem_ack or timeout
//   mem_addr     out  32  {addr[31:2],2'b00}
//   mem_byteen   out  4   byte write enables; 0000 on loads
//   mem_wdata    out  32  lane-replicated store data
//   mem_ack      in   1   bus completion (1-cycle pulse); mem_rdata valid with it
//   mem_rdata    in   32  read word
//   rd_valid     out  1   1-cycle pulse: rd_data valid (loads only)
//   rd_data      out  32  extended load result; holds last value otherwise
//   err_align    out  1   1-cycle pulse: misaligned or illegal size
//   err_timeout  out  1   1-cycle pulse: no ack within MAX_WAIT cycles
// BEHAVIOUR
//   Reset: state IDLE; stall, mem_req, rd_valid, err_* = 0; mem_byteen=0; rd_data=0; wait counter=0.
//   FSM states: IDLE, BUS, DONE, ERR.
//     IDLE, op_valid=1 and access legal: go to BUS; capture addr/byteen/wdata/op fields into registers.
//     IDLE, op_valid=1 and access illegal: go to ERR; no mem_req is issued.
//     BUS: mem_req=1 with registered outputs stable; counter increments each cycle.
//       mem_ack=1: latch mem_rdata, go to DONE.
//       counter==MAX_WAIT without ack: go to DONE with timeout flag set; mem_req drops.
//     DONE, ERR: one cycle each, then IDLE.
//       DONE asserts rd_valid (load, no timeout) or err_timeout. ERR asserts err_align.
//   Illegal access:
//     op_size=11;
//     op_size=01 with addr[0]=1;
//     op_size=00 with addr[1:0]!=0.
//   stall = (IDLE & op_valid) | BUS.
//     stall=0 in DONE/ERR so the pipeline advances; op_valid seen in DONE/ERR is the retiring op and is ignored.
//   Latency: accept at cycle 0; mem_req cycles 1..k (ack at k); DONE at k+1. Zero-wait load = 3 cycles, 2 stalled.
//   Byte enables (store): word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0].
//   Store data: word wdata; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
//   Load extension:
//     word = rdata;
//     half = rdata[16*a1 +:16];
//     byte = rdata[8*a[1:0] +:8];
//     sign bit replicated unless op_unsigned.
//   mem_ack outside BUS is ignored. Ack arriving in the same cycle the counter hits MAX_WAIT counts as success.
//   Reset mid-BUS: next edge returns to IDLE; mem_req=0, no rd_valid or err pulse.
// TESTING
//   lb addr=0x1003, rdata=0x80FF_1234, ack at cycle 1 -> rd_data=0xFFFFFF80, rd_valid at cycle 2, stall 0..1.
//   lhu addr=0x2002, rdata=0xBEEF_0001, 3 wait cycles -> rd_data=0x0000BEEF, stall held 4 cycles.
//   sb addr=0x11, wdata=0x0000_00A5 -> mem_byteen=0010, mem_wdata=0xA5A5A5A5, mem_addr=0x10, no rd_valid.
//   lw addr=0x6 -> err_align pulse next cycle, mem_req never asserted, stall 1 cycle.
//   Load, mem_ack never returns, MAX_WAIT=15 -> mem_req 15 cycles, err_timeout pulse, rd_valid=0.
//   reset in 2nd BUS cycle -> next edge mem_req=0, stall=0; following lw completes normally.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: one req/ack bus transaction per MEM-stage
// load/store, with alignment checking, store lane replication, load
// extension and a bounded wait for the bus acknowledge.
module dm_access_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        err_align,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

  localparam logic [8:0] MAX_W9 = 9'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        tout_q;
  logic [31:0] rd_data_q;
  logic [3:0]  byteen_q;
  logic [29:0] waddr_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        store_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic accept, ack_ok, tout_hit;

  function automatic logic legal_f(input logic [1:0] sz, input logic [1:0] a);
    legal_f = !((sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a != 2'b00));
  endfunction

  function automatic logic [3:0] byteen_f(input logic st, input logic [1:0] sz,
                                          input logic [1:0] a);
    byteen_f = 4'b0000;
    if (st) begin
      case (sz)
        2'b00:   byteen_f = 4'b1111;
        2'b01:   byteen_f = a[1] ? 4'b1100 : 4'b0011;
        default: byteen_f = 4'b0001 << a;
      endcase
    end
  endfunction

  function automatic logic [31:0] repl_f(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b01:   repl_f = {2{w[15:0]}};
      2'b10:   repl_f = {4{w[7:0]}};
      default: repl_f = w;
    endcase
  endfunction

  function automatic logic [31:0] extend_f(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] lane);
    logic [15:0] h;
    logic [7:0]  b;
    h = lane[1] ? w[31:16] : w[15:0];
    b = w[{lane, 3'b000} +: 8];
    case (sz)
      2'b01:   extend_f = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   extend_f = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      default: extend_f = w;
    endcase
  endfunction

  // Next-state and handshake/pulse outputs; DONE/ERR never stall so the
  // retiring op still on op_valid is not re-accepted.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    mem_req     = 1'b0;
    rd_valid    = 1'b0;
    err_align   = 1'b0;
    err_timeout = 1'b0;
    accept      = 1'b0;
    ack_ok      = 1'b0;
    tout_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        stall = op_valid;
        if (op_valid) begin
          if (legal_f(op_size, addr[1:0])) begin
            state_d = BUS;
            accept  = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUS: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = DONE;
          ack_ok  = 1'b1;
        end else if ({1'b0, cnt_q} + 9'd1 == MAX_W9) begin
          state_d  = DONE;
          tout_hit = 1'b1;
        end
      end
      DONE: begin
        rd_valid    = !store_q && !tout_q;
        err_timeout = tout_q;
        state_d     = IDLE;
      end
      default: begin
        err_align = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // Control state, wait counter, byte enables and load result (reset-cleared)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      tout_q    <= 1'b0;
      byteen_q  <= 4'b0000;
      rd_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= 8'd0;
        tout_q   <= 1'b0;
        byteen_q <= byteen_f(op_store, op_size, addr[1:0]);
      end else if (state_q == BUS) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (tout_hit) tout_q <= 1'b1;
      if (ack_ok && !store_q) rd_data_q <= extend_f(mem_rdata, size_q, uns_q, lane_q);
    end
  end

  // Captured access fields; only meaningful while the bus transaction runs
  always_ff @(posedge clk) begin
    if (accept) begin
      waddr_q <= addr[31:2];
      lane_q  <= addr[1:0];
      wdata_q <= repl_f(op_size, wdata);
      store_q <= op_store;
      size_q  <= op_size;
      uns_q   <= op_unsigned;
    end
  end

  assign mem_addr   = {waddr_q, 2'b00};
  assign mem_byteen = byteen_q;
  assign mem_wdata  = wdata_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: transaction-level reference model
// driving a bus responder with a chosen acknowledge cycle.
module tb_dm_access_ctrl;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_store, op_unsigned, mem_ack;
  logic [1:0]  op_size;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, mem_req, rd_valid, err_align, err_timeout;
  logic [31:0] mem_addr, mem_wdata, rd_data;
  logic [3:0]  mem_byteen;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rd = 32'h0;

  dm_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_store(op_store),
    .op_size(op_size), .op_unsigned(op_unsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .err_align(err_align),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic ref_legal(input logic [1:0] sz, input logic [31:0] a);
    int align;
    align = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    ref_legal = (sz != 2'd3) && ((a % align) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] a);
    int bits, sh;
    logic [31:0] v, mask;
    bits = (sz == 2'd0) ? 32 : (sz == 2'd1) ? 16 : 8;
    sh   = (sz == 2'd0) ? 0 : (sz == 2'd1) ? 16 * ((a / 2) % 2) : 8 * (a % 4);
    v    = rd >> sh;
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
    v    = v & mask;
    if (!uns && bits < 32 && v[bits-1]) v = v | ~mask;
    ref_load = v;
  endfunction

  function automatic logic [3:0] ref_byteen(input logic st, input logic [1:0] sz,
                                            input logic [31:0] a);
    int first, cnt;
    logic [3:0] m;
    m = 4'b0;
    if (st) begin
      cnt   = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
      first = (a % 4) - ((a % 4) % cnt);
      for (int i = 0; i < cnt; i++) m[first + i] = 1'b1;
    end
    ref_byteen = m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd1)      ref_wdata = (w & 32'hFFFF) * 32'h0001_0001;
    else if (sz == 2'd2) ref_wdata = (w & 32'hFF) * 32'h0101_0101;
    else                 ref_wdata = w;
  endfunction

  // One operation; k = BUS cycle in which mem_ack arrives (0 or >MAX_WAIT = never).
  // Entered and left #1 after a rising edge.
  task automatic do_op(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdw, input int k);
    logic lg, acked;
    int n, last;
    logic e_stall, e_req, e_rv, e_et, e_ea;
    logic [31:0] e_rd;
    lg    = ref_legal(sz, a);
    acked = lg && (k >= 1) && (k <= MAX_WAIT);
    n     = !lg ? 0 : (acked ? k : MAX_WAIT);
    last  = lg ? n + 1 : 1;
    e_rd  = exp_rd;
    op_valid = 1'b1; op_store = st; op_size = sz; op_unsigned = uns;
    addr = a; wdata = wd;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      e_stall = (c == 0) || (lg && c >= 1 && c <= n);
      e_req   = lg && c >= 1 && c <= n;
      e_rv    = lg && c == n + 1 && !st && acked;
      e_et    = lg && c == n + 1 && !acked;
      e_ea    = !lg && c == 1;
      if (c == last && lg && acked && !st) e_rd = ref_load(rdw, sz, uns, a);
      n_cmp += 5;
      if (stall !== e_stall) begin n_err++; $display("FAIL stall c%0d: got %b want %b", c, stall, e_stall); end
      if (mem_req !== e_req) begin n_err++; $display("FAIL mem_req c%0d: got %b want %b", c, mem_req, e_req); end
      if (rd_valid !== e_rv) begin n_err++; $display("FAIL rd_valid c%0d: got %b want %b", c, rd_valid, e_rv); end
      if (err_timeout !== e_et) begin n_err++; $display("FAIL err_timeout c%0d: got %b want %b", c, err_timeout, e_et); end
      if (err_align !== e_ea) begin n_err++; $display("FAIL err_align c%0d: got %b want %b", c, err_align, e_ea); end
      if (c == 0 || c == last) begin
        n_cmp++;
        if (rd_data !== e_rd) begin n_err++; $display("FAIL rd_data c%0d: got %h want %h", c, rd_data, e_rd); end
      end
      if (e_req) begin
        n_cmp += 3;
        if (mem_addr !== (a & 32'hFFFF_FFFC)) begin n_err++; $display("FAIL mem_addr c%0d: got %h want %h", c, mem_addr, a & 32'hFFFF_FFFC); end
        if (mem_byteen !== ref_byteen(st, sz, a)) begin n_err++; $display("FAIL mem_byteen c%0d: got %b want %b", c, mem_byteen, ref_byteen(st, sz, a)); end
        if (st && mem_wdata !== ref_wdata(sz, wd)) begin n_err++; $display("FAIL mem_wdata c%0d: got %h want %h", c, mem_wdata, ref_wdata(sz, wd)); end
      end
      @(posedge clk); #1;
      if (lg && c + 1 <= n) begin
        mem_ack   = (c + 1 == k);
        mem_rdata = (c + 1 == k) ? rdw : $urandom;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
    exp_rd   = e_rd;
    op_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op_store = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({stall, mem_req, rd_valid, err_align, err_timeout, mem_byteen} !== 9'b0 || rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset: got ctl=%b be=%b rd=%h want all zero",
               {stall, mem_req, rd_valid, err_align, err_timeout}, mem_byteen, rd_data);
    end
    exp_rd = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op(1'b0, 2'd2, 1'b0, 32'h1003, 32'h0, 32'h80FF_1234, 1);   // lb
    n_cmp++;
    if (rd_data !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_value: got %h want ffffff80", rd_data); end
    do_op(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'hBEEF_0001, 3);   // lhu
    n_cmp++;
    if (rd_data !== 32'h0000_BEEF) begin n_err++; $display("FAIL lhu_value: got %h want 0000beef", rd_data); end
    do_op(1'b1, 2'd2, 1'b0, 32'h11, 32'h0000_00A5, 32'h0, 2);      // sb
    do_op(1'b0, 2'd0, 1'b0, 32'h6, 32'h0, 32'h0, 1);               // lw misaligned
    do_op(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 32'h0, 1);               // illegal size
    do_op(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, 32'h0, 1);               // odd half
  endtask

  task automatic test_timeout();
    do_op(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 0);          // never acked
    do_op(1'b0, 2'd0, 1'b0, 32'h44, 32'h0, 32'h0BAD_F00D, MAX_WAIT);   // ack on last cycle
    do_op(1'b1, 2'd0, 1'b0, 32'h48, 32'hCAFE_BABE, 32'h0, 0);          // store timeout
  endtask

  task automatic test_reset_mid_bus();
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
    addr = 32'h100; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({stall, mem_req, rd_valid, err_align, err_timeout} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_mid_bus c%0d: got %b want 00000", c,
                 {stall, mem_req, rd_valid, err_align, err_timeout});
      end
    end
    @(posedge clk); #1;
    do_op(1'b0, 2'd0, 1'b0, 32'h200, 32'h0, 32'h1357_9BDF, 2);
  endtask

  task automatic test_random();
    logic [1:0] sz;
    int k;
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      k  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MAX_WAIT);
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, k);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid_bus();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
